// File: rtl/pll_dps_stepper.sv
// Dynamic-phase-shift stepper for the frame-clock PLL: one phase_en/phase_done handshake per step.
// Optional handshake timeout is compiled in with `define PLL_DPS_TIMEOUT_EN.
module pll_dps_stepper #(
  parameter int STEP_W      = 8,
  parameter int POS_W       = 16,
  parameter int TIMEOUT_CYC = 255,
  parameter int SETTLE_CYC  = 2
) (
  input  logic                    scanclk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [STEP_W-1:0]       req_steps,
  input  logic                    req_updn,
  input  logic [4:0]              req_cntsel,
  input  logic                    locked,
  input  logic                    phase_done,
  output logic                    phase_en,
  output logic                    updn,
  output logic [4:0]              cntsel,
  output logic                    busy,
  output logic                    done_pulse,
  output logic                    err_timeout,
  output logic                    err_lock,
  output logic signed [POS_W-1:0] phase_pos
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ASSERT,
    S_WAIT_HIGH,
    S_SETTLE,
    S_DONE
  } state_t;

  localparam int SCNT_W = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC);
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(SETTLE_CYC - 1);

  generate
    if (SETTLE_CYC < 1 || TIMEOUT_CYC < 1) begin : g_bad_param
      $error("pll_dps_stepper: SETTLE_CYC and TIMEOUT_CYC must be at least 1");
    end
  endgenerate

  // Two-flop synchronizers; bit 1 = locked, bit 0 = phase_done.
  logic [1:0] meta_reg;
  logic [1:0] sync_reg;
  logic       lk_s;
  logic       pd_s;

  always_ff @(posedge scanclk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= 2'b00;
      sync_reg <= 2'b00;
    end else begin
      meta_reg <= {locked, phase_done};
      sync_reg <= meta_reg;
    end
  end

  assign lk_s = sync_reg[1];
  assign pd_s = sync_reg[0];

  state_t                    state_reg, state_next;
  logic [STEP_W-1:0]         remaining_reg, remaining_next;
  logic signed [POS_W-1:0]   pos_reg, pos_next;
  logic                      updn_reg, updn_next;
  logic [4:0]                cntsel_reg, cntsel_next;
  logic                      err_lock_reg, err_lock_next;
  logic [SCNT_W-1:0]         settle_reg, settle_next;
  logic                      accept;
  logic                      timeout_hit;

  assign accept = (state_reg == S_IDLE) && req_valid && lk_s;

  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    pos_next       = pos_reg;
    updn_next      = updn_reg;
    cntsel_next    = cntsel_reg;
    err_lock_next  = err_lock_reg;
    settle_next    = settle_reg;
    case (state_reg)
      S_IDLE: begin
        if (accept) begin
          updn_next      = req_updn;
          cntsel_next    = req_cntsel;
          remaining_next = req_steps;
          err_lock_next  = 1'b0;
          state_next     = (req_steps == '0) ? S_DONE : S_ASSERT;
        end
      end
      S_ASSERT: begin
        if (!lk_s) begin
          err_lock_next = 1'b1;
          state_next    = S_DONE;
        end else if (!pd_s) begin
          state_next = S_WAIT_HIGH;
        end else if (timeout_hit) begin
          state_next = S_DONE;
        end
      end
      S_WAIT_HIGH: begin
        // Lock loss is checked first so an interrupted step never moves the position.
        if (!lk_s) begin
          err_lock_next = 1'b1;
          state_next    = S_DONE;
        end else if (pd_s) begin
          pos_next       = updn_reg ? (pos_reg + POS_W'(1)) : (pos_reg - POS_W'(1));
          remaining_next = remaining_reg - STEP_W'(1);
          settle_next    = '0;
          state_next     = (remaining_reg == STEP_W'(1)) ? S_DONE : S_SETTLE;
        end else if (timeout_hit) begin
          state_next = S_DONE;
        end
      end
      S_SETTLE: begin
        if (!lk_s) begin
          err_lock_next = 1'b1;
          state_next    = S_DONE;
        end else if (settle_reg == SCNT_LAST) begin
          state_next = S_ASSERT;
        end else begin
          settle_next = settle_reg + SCNT_W'(1);
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge scanclk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      remaining_reg <= '0;
      pos_reg       <= '0;
      updn_reg      <= 1'b0;
      cntsel_reg    <= 5'd0;
      err_lock_reg  <= 1'b0;
      settle_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      remaining_reg <= remaining_next;
      pos_reg       <= pos_next;
      updn_reg      <= updn_next;
      cntsel_reg    <= cntsel_next;
      err_lock_reg  <= err_lock_next;
      settle_reg    <= settle_next;
    end
  end

`ifdef PLL_DPS_TIMEOUT_EN
  // Counter holds 0..TIMEOUT_CYC-1, so a stuck state lasts exactly TIMEOUT_CYC cycles.
  localparam int TCNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYC - 1);

  logic [TCNT_W-1:0] tcnt_reg, tcnt_next;
  logic              err_timeout_reg, err_timeout_next;
  logic              timeout_abort;

  assign timeout_hit   = (tcnt_reg == TCNT_LAST);
  assign timeout_abort = timeout_hit && lk_s &&
                         (((state_reg == S_ASSERT) && pd_s) ||
                          ((state_reg == S_WAIT_HIGH) && !pd_s));

  always_comb begin
    tcnt_next = '0;
    if ((state_next == state_reg) &&
        ((state_reg == S_ASSERT) || (state_reg == S_WAIT_HIGH))) begin
      tcnt_next = tcnt_reg + TCNT_W'(1);
    end
  end

  always_comb begin
    err_timeout_next = err_timeout_reg;
    if (accept) begin
      err_timeout_next = 1'b0;
    end else if (timeout_abort) begin
      err_timeout_next = 1'b1;
    end
  end

  always_ff @(posedge scanclk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt_reg        <= '0;
      err_timeout_reg <= 1'b0;
    end else begin
      tcnt_reg        <= tcnt_next;
      err_timeout_reg <= err_timeout_next;
    end
  end

  assign err_timeout = err_timeout_reg;
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

  assign req_ready  = (state_reg == S_IDLE) && lk_s;
  assign phase_en   = (state_reg == S_ASSERT);
  assign busy       = (state_reg != S_IDLE);
  assign done_pulse = (state_reg == S_DONE);
  assign updn       = updn_reg;
  assign cntsel     = cntsel_reg;
  assign err_lock   = err_lock_reg;
  assign phase_pos  = pos_reg;

endmodule

// File: tb/tb_pll_dps_stepper.sv
// Directed bench for pll_dps_stepper: table of step requests plus hand-written lock-loss,
// wrap, timeout and asynchronous-reset sequences against a simple PLL phase_done model.
module tb_pll_dps_stepper;
  localparam int STEP_W = 8;
  localparam int POS_W  = 16;

  logic              scanclk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic [STEP_W-1:0] req_steps = '0;
  logic              req_updn = 1'b0;
  logic [4:0]        req_cntsel = 5'd0;
  logic              locked = 1'b0;
  logic              phase_done = 1'b1;

  logic              req_ready, phase_en, updn, busy, done_pulse, err_timeout, err_lock;
  logic [4:0]        cntsel;
  logic [POS_W-1:0]  phase_pos;

  logic              req_ready_w, phase_en_w, updn_w, busy_w, done_pulse_w, err_timeout_w, err_lock_w;
  logic [4:0]        cntsel_w;
  logic [3:0]        phase_pos_w;

  pll_dps_stepper #(.STEP_W(STEP_W), .POS_W(POS_W), .TIMEOUT_CYC(255), .SETTLE_CYC(2)) dut (
    .scanclk(scanclk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_steps(req_steps), .req_updn(req_updn), .req_cntsel(req_cntsel), .locked(locked),
    .phase_done(phase_done), .phase_en(phase_en), .updn(updn), .cntsel(cntsel), .busy(busy),
    .done_pulse(done_pulse), .err_timeout(err_timeout), .err_lock(err_lock), .phase_pos(phase_pos)
  );

  // Narrow-position twin driven identically, used to observe the signed wrap at max positive.
  pll_dps_stepper #(.STEP_W(STEP_W), .POS_W(4), .TIMEOUT_CYC(255), .SETTLE_CYC(2)) dut_w (
    .scanclk(scanclk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready_w),
    .req_steps(req_steps), .req_updn(req_updn), .req_cntsel(req_cntsel), .locked(locked),
    .phase_done(phase_done), .phase_en(phase_en_w), .updn(updn_w), .cntsel(cntsel_w), .busy(busy_w),
    .done_pulse(done_pulse_w), .err_timeout(err_timeout_w), .err_lock(err_lock_w), .phase_pos(phase_pos_w)
  );

  always #5 scanclk = ~scanclk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // PLL model: phase_done falls 2 cycles after phase_en is seen and rises 4 cycles later.
  logic pll_respond = 1'b1;
  initial begin
    forever begin
      @(negedge scanclk);
      if (pll_respond && phase_en && rst_n) begin
        repeat (2) @(negedge scanclk);
        phase_done = 1'b0;
        repeat (4) @(negedge scanclk);
        phase_done = 1'b1;
      end
    end
  end

  int         pe_rises = 0;
  int         done_cnt = 0;
  int         long_done = 0;
  int         low_run = 0;
  int         last_gap = 0;
  int         unstable = 0;
  logic       pe_prev = 1'b0;
  logic       done_prev = 1'b0;
  logic       exp_updn = 1'b0;
  logic [4:0] exp_cntsel = 5'd0;

  always @(negedge scanclk) begin
    pe_prev   <= phase_en;
    done_prev <= done_pulse;
    if (phase_en && !pe_prev) begin
      pe_rises <= pe_rises + 1;
      last_gap <= low_run;
      low_run  <= 0;
    end else if (!phase_en) begin
      low_run <= low_run + 1;
    end
    if (done_pulse) done_cnt <= done_cnt + 1;
    if (done_pulse && done_prev) long_done <= long_done + 1;
    if (busy && (updn !== exp_updn || cntsel !== exp_cntsel)) unstable <= unstable + 1;
  end

  task automatic do_req(input int steps, input logic ud, input logic [4:0] cs);
    for (int i = 0; i < 200 && !req_ready; i++) @(negedge scanclk);
    check("req_ready_before_req", req_ready, 1);
    exp_updn   = ud;
    exp_cntsel = cs;
    req_valid  = 1'b1;
    req_steps  = STEP_W'(steps);
    req_updn   = ud;
    req_cntsel = cs;
    @(negedge scanclk);
    req_valid = 1'b0;
    check("accept_busy", busy, 1);
    check("accept_phase_en", phase_en, (steps != 0) ? 1 : 0);
    if (steps == 0) check("zero_step_done_pulse", done_pulse, 1);
    for (int i = 0; i < 2000 && busy; i++) @(negedge scanclk);
    check("busy_drops", busy, 0);
  endtask

  typedef struct {
    int          steps;
    logic        ud;
    logic [4:0]  cs;
    int          exp_pulses;
    logic [15:0] exp_pos;
  } vec_t;

  vec_t vecs[3];
  int   base_pe;
  int   base_done;
  int   n;

  initial begin
    vecs[0] = '{3, 1'b1, 5'd0, 3, 16'h0003};
    vecs[1] = '{5, 1'b0, 5'd2, 5, 16'hFFFE};
    vecs[2] = '{0, 1'b1, 5'd7, 0, 16'hFFFE};

    // Reset state
    #1;
    check("rst_phase_en", phase_en, 0);
    check("rst_busy", busy, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_done_pulse", done_pulse, 0);
    check("rst_err_lock", err_lock, 0);
    check("rst_err_timeout", err_timeout, 0);
    check("rst_updn_cntsel", {updn, cntsel}, 0);
    check("rst_phase_pos", phase_pos, 0);
    repeat (2) @(negedge scanclk);
    rst_n  = 1'b1;
    locked = 1'b1;
    @(negedge scanclk);
    check("ready_after_1_cycle", req_ready, 0);
    @(negedge scanclk);
    check("ready_after_2_cycles", req_ready, 1);

    for (int v = 0; v < 3; v++) begin
      base_pe   = pe_rises;
      base_done = done_cnt;
      do_req(vecs[v].steps, vecs[v].ud, vecs[v].cs);
      #1;
      check($sformatf("v%0d_phase_en_pulses", v), pe_rises - base_pe, vecs[v].exp_pulses);
      check($sformatf("v%0d_done_pulses", v), done_cnt - base_done, 1);
      check($sformatf("v%0d_phase_pos", v), phase_pos, vecs[v].exp_pos);
      check($sformatf("v%0d_cntsel", v), cntsel, vecs[v].cs);
      check($sformatf("v%0d_updn", v), updn, vecs[v].ud);
      check($sformatf("v%0d_err_lock", v), err_lock, 0);
      check($sformatf("v%0d_err_timeout", v), err_timeout, 0);
      check($sformatf("v%0d_unstable_cycles", v), unstable, 0);
      if (v == 0) check("settle_gap_cycles", last_gap, 6);
    end
    check("done_pulse_width", long_done, 0);

    // Lock loss during step 2 of 4
    base_pe = pe_rises;
    for (int i = 0; i < 200 && !req_ready; i++) @(negedge scanclk);
    exp_updn = 1'b1; exp_cntsel = 5'd1;
    req_valid = 1'b1; req_steps = STEP_W'(4); req_updn = 1'b1; req_cntsel = 5'd1;
    @(negedge scanclk);
    req_valid = 1'b0;
    for (int i = 0; i < 500 && pe_rises < base_pe + 2; i++) begin
      @(negedge scanclk);
      #1;
    end
    check("lock_step2_started", pe_rises - base_pe, 2);
    locked = 1'b0;
    n = 0;
    while (phase_en && n < 10) begin
      @(negedge scanclk);
      n++;
    end
    check("lock_phase_en_drop_cycles", n, 3);
    check("lock_done_pulse", done_pulse, 1);
    check("lock_err_lock", err_lock, 1);
    @(negedge scanclk);
    check("lock_busy_low", busy, 0);
    check("lock_phase_pos", phase_pos, 16'hFFFF);
    repeat (5) @(negedge scanclk);
    check("lock_ready_held_low", req_ready, 0);
    locked = 1'b1;
    @(negedge scanclk);
    check("relock_ready_1_cycle", req_ready, 0);
    @(negedge scanclk);
    check("relock_ready_2_cycles", req_ready, 1);
    check("lock_err_lock_sticky", err_lock, 1);
    repeat (10) @(negedge scanclk);

    // Walk the 4-bit twin to +7, then one more up step wraps to -8
    do_req(8, 1'b1, 5'd3);
    check("wrap_pre_pos", phase_pos, 16'h0007);
    check("wrap_pre_pos_w", phase_pos_w, 4'h7);
    check("accept_clears_err_lock", err_lock, 0);
    do_req(1, 1'b1, 5'd3);
    check("wrap_pos", phase_pos, 16'h0008);
    check("wrap_pos_w", phase_pos_w, 4'h8);

`ifdef PLL_DPS_TIMEOUT_EN
    pll_respond = 1'b0;
    for (int i = 0; i < 200 && !req_ready; i++) @(negedge scanclk);
    exp_updn = 1'b1; exp_cntsel = 5'd4;
    req_valid = 1'b1; req_steps = STEP_W'(1); req_updn = 1'b1; req_cntsel = 5'd4;
    @(negedge scanclk);
    req_valid = 1'b0;
    n = 0;
    while (phase_en && n < 400) begin
      @(negedge scanclk);
      n++;
    end
    check("timeout_phase_en_cycles", n, 255);
    check("timeout_done_pulse", done_pulse, 1);
    check("timeout_err_timeout", err_timeout, 1);
    check("timeout_phase_pos", phase_pos, 16'h0008);
    pll_respond = 1'b1;
    do_req(0, 1'b0, 5'd4);
    check("accept_clears_err_timeout", err_timeout, 0);
`endif

    // Asynchronous reset mid-step
    for (int i = 0; i < 200 && !req_ready; i++) @(negedge scanclk);
    exp_updn = 1'b1; exp_cntsel = 5'd9;
    req_valid = 1'b1; req_steps = STEP_W'(2); req_updn = 1'b1; req_cntsel = 5'd9;
    @(negedge scanclk);
    req_valid = 1'b0;
    check("midreset_phase_en_high", phase_en, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_phase_en", phase_en, 0);
    check("midreset_busy", busy, 0);
    check("midreset_phase_pos", phase_pos, 0);
    check("midreset_updn_cntsel", {updn, cntsel}, 0);
    check("midreset_ready", req_ready, 0);
    check("midreset_flags", {done_pulse, err_lock, err_timeout}, 0);
    check("midreset_phase_pos_w", phase_pos_w, 0);
    @(negedge scanclk);
    rst_n = 1'b1;
    @(negedge scanclk);
    check("postreset_ready_low", req_ready, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
